// File: rtl/pps_pkg.sv
// Shared state encoding and default parameter values for the PPS period meter.
package pps_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOST    = 2'd2
    } pps_state_t;

    localparam int unsigned DEF_CNT_W       = 32;
    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam logic [31:0] DEF_TIMEOUT_CYC = 32'd15_000_000;
    localparam int unsigned DEF_TOL         = 16;
    localparam int unsigned DEF_LOCK_N      = 4;

endpackage

// File: rtl/pps_sync_edge.sv
// Brings an asynchronous pulse into the clk domain and emits a registered
// one-cycle strobe on each rising edge of the synchronized level.
module pps_sync_edge
    import pps_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic edge_out
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;
    logic                   edge_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            last_q <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            last_q <= sync_q[SYNC_STAGES-1];
            edge_q <= sync_q[SYNC_STAGES-1] & ~last_q;
        end
    end

    assign edge_out = edge_q;

endmodule

// File: rtl/pps_period_meter.sv
// Measures clk cycles between PPS rising edges, tracks lock/timeout and hands
// each period word to a consumer through a one-entry valid/ready slot.
module pps_period_meter
    import pps_pkg::*;
#(
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter logic [31:0] TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int unsigned TOL         = DEF_TOL,
    parameter int unsigned LOCK_N      = DEF_LOCK_N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pps_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    input  logic             period_ready,
    output logic             locked,
    output logic             timeout,
    output logic             overrun,
    input  logic             overrun_clr
);

    localparam int unsigned      LCW      = $clog2(LOCK_N + 1);
    localparam logic [CNT_W-1:0] TO_VAL   = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W:0]   TOL_VAL  = (CNT_W+1)'(TOL);
    localparam logic [LCW-1:0]   LOCK_VAL = LCW'(LOCK_N);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [CNT_W:0] abs_diff(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
        logic signed [CNT_W:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return d[CNT_W] ? $unsigned(-d) : $unsigned(d);
    endfunction

    logic             edge_s;
    pps_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             locked_q, locked_d;
    logic             timeout_q, timeout_d;
    logic [LCW-1:0]   lock_cnt_q, lock_cnt_d;
    logic [CNT_W-1:0] prev_q, prev_d;
    logic             seeded_q, seeded_d;
    logic             accept;
    logic             result;
    logic [CNT_W:0]   diff;

    pps_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk     (clk),
        .rst     (rst),
        .async_in(pps_in),
        .edge_out(edge_s)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        period_d   = period_q;
        valid_d    = valid_q;
        overrun_d  = overrun_q;
        locked_d   = locked_q;
        timeout_d  = 1'b0;
        lock_cnt_d = lock_cnt_q;
        prev_d     = prev_q;
        seeded_d   = seeded_q;
        result     = 1'b0;
        accept     = valid_q & period_ready;
        diff       = abs_diff(cnt_q, prev_q);

        if (accept) begin
            valid_d = 1'b0;
        end
        if (overrun_clr) begin
            overrun_d = 1'b0;
        end

        case (state_q)
            IDLE, LOST: begin
                // A first edge only starts the count; no previous result exists.
                if (edge_s) begin
                    state_d  = MEASURE;
                    cnt_d    = CNT_W'(1);
                    seeded_d = 1'b0;
                end
            end
            MEASURE: begin
                if (edge_s) begin
                    cnt_d  = CNT_W'(1);
                    result = 1'b1;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                    if (cnt_q == TO_VAL) begin
                        state_d    = LOST;
                        timeout_d  = 1'b1;
                        lock_cnt_d = '0;
                        locked_d   = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (result) begin
            if (!valid_q || accept) begin
                period_d = cnt_q;
                valid_d  = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
            // Lock tracking sees every result, including ones dropped above.
            prev_d = cnt_q;
            if (!seeded_q) begin
                seeded_d   = 1'b1;
                lock_cnt_d = '0;
                locked_d   = 1'b0;
            end else if (diff <= TOL_VAL) begin
                lock_cnt_d = (lock_cnt_q == LOCK_VAL) ? lock_cnt_q : lock_cnt_q + LCW'(1);
                locked_d   = (lock_cnt_d == LOCK_VAL);
            end else begin
                lock_cnt_d = '0;
                locked_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            period_q   <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
            locked_q   <= 1'b0;
            timeout_q  <= 1'b0;
            lock_cnt_q <= '0;
            prev_q     <= '0;
            seeded_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
            locked_q   <= locked_d;
            timeout_q  <= timeout_d;
            lock_cnt_q <= lock_cnt_d;
            prev_q     <= prev_d;
            seeded_q   <= seeded_d;
        end
    end

    assign period       = period_q;
    assign period_valid = valid_q;
    assign locked       = locked_q;
    assign timeout      = timeout_q;
    assign overrun      = overrun_q;

endmodule

// File: doc/pps_period_meter.md
# pps_period_meter

Measures the period, in `clk` cycles, between rising edges of an external pulse input (GPS PPS or a divided reference tick). It also reports lock and timeout status. It is the receiving end of the tick path: a prescaler produces periodic one-cycle strobes, and this block consumes such a pulse stream (synchronous or asynchronous) and turns it into period words for the discipline/logging logic. Results are handed off over a one-entry valid/ready interface.

## Interface
- `CNT_W`, 32, width of period counter and result.
- `SYNC_STAGES`, 2, synchronizer flops on `pps_in` (≥2).
- `TIMEOUT_CYC`, 32'd15_000_000, cycles without an edge before declaring loss.
- `TOL`, 16, max |period − previous period| counted as consistent.
- `LOCK_N`, 4, consecutive consistent periods required for lock.
- `clk` input 1 system clock.
- `rst` input 1 reset. One clock; reset is synchronous and active-high.
- `pps_in` input 1 pulse input, asynchronous to `clk`, pulse width ≥ 2 `clk` cycles.
- `period` output CNT_W last measured period; held while `period_valid`.
- `period_valid` output 1 result available.
- `period_ready` input 1 consumer accepts on `period_valid & period_ready`.
- `locked` output 1 stable-period indication.
- `timeout` output 1 one-cycle strobe on loss of pulse.
- `overrun` output 1 sticky; a result was dropped because the slot was full.
- `overrun_clr` input 1 clears `overrun`.

## Operation
- States: `IDLE` (no reference edge yet), `MEASURE` (counting since last edge), `LOST` (timed out).
- Edge strobe `edge_s`: a one-cycle pulse on the rising edge of the synchronized `pps_in`.
- Counter `cnt`:
  - On `edge_s`: `cnt <= 1`.
  - Otherwise in `MEASURE`: `cnt <= cnt + 1`, saturating at all-ones.
- `IDLE` + `edge_s` → `MEASURE`. No result is emitted.
- `MEASURE` + `edge_s`:
  - Result = `cnt`, which equals the distance in cycles between the two strobes.
  - Stays in `MEASURE`.
- `MEASURE` with `cnt == TIMEOUT_CYC` and no `edge_s` in that cycle:
  - → `LOST`, `timeout` pulses for 1 cycle.
  - `locked` drops and the lock counter clears.
- `LOST` + `edge_s` → `MEASURE`, with no result (same as `IDLE`).
- Result slot (one entry):
  - If the slot is empty, or emptied by a handshake in the same cycle, the result is loaded and `period_valid` is asserted.
  - If the slot is full and not being accepted, the new result is dropped, `overrun <= 1`, and the held `period` is unchanged.
  - `overrun_clr` and a new overrun in the same cycle: set wins.
- Lock:
  - Each result is compared with the previous result (CNT_W+1 signed difference, absolute value).
  - Difference ≤ `TOL`: `lock_cnt` increments, saturating at `LOCK_N`.
  - Otherwise: `lock_cnt <= 0` and `locked <= 0`.
  - The first result after `IDLE`/`LOST` only seeds `prev` and leaves `lock_cnt` at 0.
  - `locked <= (lock_cnt_next == LOCK_N)`.
  - Dropped (overrun) results still update `prev` and lock.

## Timing
- Reset values: `period=0`, `period_valid=0`, `locked=0`, `timeout=0`, `overrun=0`; state `IDLE`, `cnt=0`, `lock_cnt=0`, `prev=0`.
- Synchronizer flops also clear on `rst`.
- Latency:
  - `pps_in` high at sampling edge k → `edge_s` high in cycle k+SYNC_STAGES.
  - `period_valid` and `locked` update in cycle k+SYNC_STAGES+1.
- `period_valid` stays high until the handshake. `period_valid` never depends combinationally on `period_ready`.
- Edge in the same cycle that `cnt` hits `TIMEOUT_CYC`: the edge wins, a result is emitted, and there is no timeout.
- `rst` mid-measurement aborts everything. The next edge is treated as a first edge.

## Structure
- Package `pps_pkg`: state enum `pps_state_t {IDLE, MEASURE, LOST}`, default parameter constants.
- Sub-module `pps_sync_edge` (`clk`, `rst`, `async_in`, `edge_out`; parameter `SYNC_STAGES`): the synchronizer chain plus the rising-edge detector.
- The top level holds the FSM, counter, result slot and lock logic.

## Test plan
Parameters for all scenarios: `TIMEOUT_CYC=100`, `TOL=2`, `LOCK_N=3`, `SYNC_STAGES=2`.
- Pulses every 50 cycles, `period_ready=1` → first result after the second pulse is `period=50`. Results arrive at 50-cycle spacing, `period_valid` 1 cycle each.
- Periods 50, 51, 49, 50 → `locked` rises with the 4th result (3 consistent diffs). A following period of 60 → `locked` falls in that result cycle.
- Pulse stream stops → `timeout` pulses exactly 100 cycles after the last `edge_s` and `locked=0`. The next two pulses 40 apart give one result of 40, not a stale value.
- `period_ready=0` across two results of 50 then 52 → `period` holds 50 and `overrun=1`. `overrun_clr` clears it.
- Pulse landing on the timeout cycle (spacing exactly 100) → `period=100` and no `timeout`.
- `rst` asserted 20 cycles after an edge → all outputs at reset values. The next pulse produces no result.
